cpu_program_loader: RTL and testbench

//  Pin-driven program loader feeding the CPU bootloader port (bl_programm/bl_data/bl_address/bl_write_en_mem).

---
 rtl/cpu_program_loader_if.sv | 30 +++
 rtl/cpu_program_loader.sv | 132 +++++++++++++
 tb/tb_cpu_program_loader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_program_loader_if.sv
// Host handshake and bootloader bus bundle for the program loader.
// The loader sits on the slave side; the host/top level sits on the master side.
interface cpu_program_loader_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4
);
  logic                  prog_en_i;
  logic                  strobe_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  ack_o;
  logic                  bl_programm_o;
  logic [DATA_WIDTH-1:0] bl_data_o;
  logic [ADDR_WIDTH-1:0] bl_address_o;
  logic                  bl_write_en_mem_o;
  logic [ADDR_WIDTH:0]   word_count_o;
  logic                  full_o;
  logic                  overflow_o;

  modport slave (
    input  prog_en_i, strobe_i, data_i,
    output ack_o, bl_programm_o, bl_data_o, bl_address_o, bl_write_en_mem_o,
           word_count_o, full_o, overflow_o
  );

  modport master (
    output prog_en_i, strobe_i, data_i,
    input  ack_o, bl_programm_o, bl_data_o, bl_address_o, bl_write_en_mem_o,
           word_count_o, full_o, overflow_o
  );
endinterface

// File: rtl/cpu_program_loader.sv
// Pin-driven program loader: a host shifts words in over a 4-phase
// strobe/ack handshake; each word is written to the CPU bootloader port at
// an auto-incrementing address while the CPU is held in programming mode.
module cpu_program_loader #(
  parameter int DATA_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 4,
  parameter int MEM_DEPTH   = 16,
  parameter int SYNC_STAGES = 2,
  parameter bit WRAP_EN     = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  cpu_program_loader_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE, S_ACK} state_t;

  state_t                  state, state_nxt;
  logic [SYNC_STAGES-1:0]  pe_sync, stb_sync;
  logic                    pe_s, stb_s, stb_s_q, stb_rise;
  logic                    session_start, load_word, word_done, flag_ovf;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH:0]     count_q;
  logic                    full_q, ovf_q;
  logic [DATA_WIDTH-1:0]   data_q;

  assign pe_s     = pe_sync[SYNC_STAGES-1];
  assign stb_s    = stb_sync[SYNC_STAGES-1];
  assign stb_rise = stb_s & ~stb_s_q;

  // Bring the asynchronous host pins into the clock domain and keep the
  // previous strobe level so only a fresh 0->1 edge starts a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_sync  <= '0;
      stb_sync <= '0;
      stb_s_q  <= 1'b0;
    end else begin
      pe_sync  <= {pe_sync[SYNC_STAGES-2:0], bus.prog_en_i};
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], bus.strobe_i};
      stb_s_q  <= stb_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt     = state;
    session_start = 1'b0;
    load_word     = 1'b0;
    word_done     = 1'b0;
    flag_ovf      = 1'b0;
    case (state)
      S_IDLE: begin
        if (pe_s) begin
          session_start = 1'b1;
          state_nxt     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!pe_s) begin
          state_nxt = S_IDLE;
        end else if (stb_rise) begin
          if (full_q) begin
            // Memory exhausted: acknowledge so the host is not stalled, but record it.
            flag_ovf  = 1'b1;
            state_nxt = S_ACK;
          end else begin
            load_word = 1'b1;
            state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // A falling prog_en never cuts a write short; it is honoured after ACK.
        word_done = 1'b1;
        state_nxt = S_ACK;
      end
      S_ACK: begin
        if (!stb_s) state_nxt = pe_s ? S_WAIT : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address, word counter, status flags and the captured word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      if (session_start) begin
        addr_q  <= '0;
        count_q <= '0;
        full_q  <= 1'b0;
        ovf_q   <= 1'b0;
      end
      if (load_word) data_q <= bus.data_i;
      if (flag_ovf && !WRAP_EN) ovf_q <= 1'b1;
      if (word_done) begin
        if (count_q != DEPTH_CNT) count_q <= count_q + 1'b1;
        if (addr_q == LAST_ADDR) begin
          if (WRAP_EN) addr_q <= '0;
          else         full_q <= 1'b1;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end
    end
  end

  assign bus.bl_programm_o     = (state != S_IDLE);
  assign bus.bl_write_en_mem_o = (state == S_WRITE);
  assign bus.ack_o             = (state == S_ACK);
  assign bus.bl_data_o         = data_q;
  assign bus.bl_address_o      = addr_q;
  assign bus.word_count_o      = count_q;
  assign bus.full_o            = full_q;
  assign bus.overflow_o        = ovf_q;

endmodule

// File: tb/tb_cpu_program_loader.sv
// Testbench for cpu_program_loader: a saturating and a wrapping instance
// are driven by the same host pins and checked against directed expectations.
module tb_cpu_program_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       prog_en = 1'b0;
  logic       strobe = 1'b0;
  logic [3:0] data = 4'h0;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] wq_s[$];
  logic [7:0] wq_w[$];

  typedef struct {
    logic [3:0] data;
    logic [3:0] addr;
  } vec_t;
  vec_t basic[3];

  always #5 clk = ~clk;

  cpu_program_loader_if #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) ifs ();
  cpu_program_loader_if #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) ifw ();

  assign ifs.prog_en_i = prog_en;
  assign ifs.strobe_i  = strobe;
  assign ifs.data_i    = data;
  assign ifw.prog_en_i = prog_en;
  assign ifw.strobe_i  = strobe;
  assign ifw.data_i    = data;

  cpu_program_loader #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .MEM_DEPTH(16),
                       .SYNC_STAGES(2), .WRAP_EN(1'b0))
    u_sat (.clk(clk), .rst_n(rst_n), .bus(ifs.slave));

  cpu_program_loader #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .MEM_DEPTH(16),
                       .SYNC_STAGES(2), .WRAP_EN(1'b1))
    u_wrap (.clk(clk), .rst_n(rst_n), .bus(ifw.slave));

  // Record every write pulse as {address, data}.
  always @(negedge clk) begin
    if (ifs.bl_write_en_mem_o) wq_s.push_back({ifs.bl_address_o, ifs.bl_data_o});
    if (ifw.bl_write_en_mem_o) wq_w.push_back({ifw.bl_address_o, ifw.bl_data_o});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctrl_s"}, 32'({ifs.bl_programm_o, ifs.ack_o, ifs.bl_write_en_mem_o, ifs.full_o, ifs.overflow_o}), 32'd0);
    check({tag, "_regs_s"}, 32'({ifs.word_count_o, ifs.bl_address_o, ifs.bl_data_o}), 32'd0);
    check({tag, "_ctrl_w"}, 32'({ifw.bl_programm_o, ifw.ack_o, ifw.bl_write_en_mem_o, ifw.full_o, ifw.overflow_o}), 32'd0);
    check({tag, "_regs_w"}, 32'({ifw.word_count_o, ifw.bl_address_o, ifw.bl_data_o}), 32'd0);
  endtask

  task automatic expect_write(input string name, input bit wrap, input logic [3:0] a, input logic [3:0] d);
    logic [7:0] w;
    if (wrap) begin
      if (wq_w.size() == 0) check({name, "_w_present"}, 32'd0, 32'd1);
      else begin
        w = wq_w.pop_front();
        check({name, "_w"}, 32'(w), 32'({a, d}));
      end
    end else begin
      if (wq_s.size() == 0) check({name, "_s_present"}, 32'd0, 32'd1);
      else begin
        w = wq_s.pop_front();
        check({name, "_s"}, 32'(w), 32'({a, d}));
      end
    end
  endtask

  task automatic wait_ack_fall(input string name);
    int k = 0;
    while ((ifs.ack_o || ifw.ack_o) && k < 12) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'({ifs.ack_o, ifw.ack_o}), 32'd0);
  endtask

  task automatic wait_ack_rise(input string name);
    int k = 0;
    while (!(ifs.ack_o && ifw.ack_o) && k < 12) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'({ifs.ack_o, ifw.ack_o}), 32'd3);
  endtask

  task automatic send_word(input logic [3:0] d);
    @(posedge clk); #1;
    data   = d;
    strobe = 1'b1;
    wait_ack_rise("ack_rise");
    strobe = 1'b0;
    wait_ack_fall("ack_fall");
  endtask

  task automatic start_session();
    prog_en = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic end_session();
    prog_en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    basic[0] = '{data: 4'h3, addr: 4'h0};
    basic[1] = '{data: 4'hA, addr: 4'h1};
    basic[2] = '{data: 4'h5, addr: 4'h2};

    // Reset state
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic load
    start_session();
    check("programm_on", 32'({ifs.bl_programm_o, ifw.bl_programm_o}), 32'd3);
    for (int i = 0; i < 3; i++) begin
      send_word(basic[i].data);
      expect_write("basic", 1'b0, basic[i].addr, basic[i].data);
      expect_write("basic", 1'b1, basic[i].addr, basic[i].data);
    end
    check("basic_count", 32'({ifs.word_count_o, ifw.word_count_o}), 32'({5'd3, 5'd3}));

    // Cycle-exact latency from strobe to write pulse and ack
    @(posedge clk); #1;
    data   = 4'h7;
    strobe = 1'b1;
    @(posedge clk); #1;
    check("lat_e0", 32'({ifs.bl_write_en_mem_o, ifs.ack_o}), 32'd0);
    @(posedge clk); #1;
    check("lat_e1", 32'({ifs.bl_write_en_mem_o, ifs.ack_o}), 32'd0);
    @(posedge clk); #1;
    check("lat_e2", 32'({ifs.bl_write_en_mem_o, ifs.ack_o}), 32'b10);
    @(posedge clk); #1;
    check("lat_e3", 32'({ifs.bl_write_en_mem_o, ifs.ack_o}), 32'b01);
    strobe = 1'b0;
    wait_ack_fall("lat_ack_fall");
    expect_write("lat", 1'b0, 4'h3, 4'h7);
    expect_write("lat", 1'b1, 4'h3, 4'h7);
    check("lat_count", 32'(ifs.word_count_o), 32'd4);

    // Saturate vs wrap over 18 words
    end_session();
    start_session();
    check("new_session_s", 32'({ifs.word_count_o, ifs.bl_address_o}), 32'd0);
    for (int i = 0; i < 18; i++) begin
      send_word(4'(i + 1));
      if (i < 16) expect_write("sat", 1'b0, 4'(i), 4'(i + 1));
      else check("sat_no_write", 32'(wq_s.size()), 32'd0);
      expect_write("wrap", 1'b1, 4'(i), 4'(i + 1));
      if (i == 14) check("sat_not_full_14", 32'(ifs.full_o), 32'd0);
      if (i == 15) check("full_16", 32'({ifs.full_o, ifs.overflow_o, ifw.full_o}), 32'b100);
      if (i == 16) check("ovf_17", 32'({ifs.full_o, ifs.overflow_o, ifs.word_count_o}), 32'({2'b11, 5'd16}));
    end
    check("sat_end", 32'({ifs.word_count_o, ifs.bl_address_o}), 32'({5'd16, 4'hF}));
    check("wrap_end", 32'({ifw.word_count_o, ifw.bl_address_o, ifw.full_o, ifw.overflow_o}),
          32'({5'd16, 4'h2, 2'b00}));

    // New session clears counters, keeps last data word
    end_session();
    check("idle_programm", 32'({ifs.bl_programm_o, ifw.bl_programm_o}), 32'd0);
    start_session();
    check("clr_s", 32'({ifs.word_count_o, ifs.bl_address_o, ifs.full_o, ifs.overflow_o}), 32'd0);
    check("clr_w", 32'({ifw.word_count_o, ifw.bl_address_o}), 32'd0);
    check("data_hold_w", 32'(ifw.bl_data_o), 32'h2);

    // prog_en dropped so that it falls inside the write cycle
    @(posedge clk); #1;
    data   = 4'h9;
    strobe = 1'b1;
    @(posedge clk); #1;
    prog_en = 1'b0;
    check("pd_e0", 32'(ifs.bl_write_en_mem_o), 32'd0);
    @(posedge clk); #1;
    check("pd_e1", 32'(ifs.bl_write_en_mem_o), 32'd0);
    @(posedge clk); #1;
    check("pd_write", 32'({ifs.bl_write_en_mem_o, ifw.bl_write_en_mem_o, ifs.bl_programm_o}), 32'b111);
    @(posedge clk); #1;
    check("pd_ack", 32'({ifs.ack_o, ifw.ack_o, ifs.bl_programm_o}), 32'b111);
    strobe = 1'b0;
    wait_ack_fall("pd_ack_fall");
    check("pd_idle", 32'({ifs.bl_programm_o, ifw.bl_programm_o}), 32'd0);
    expect_write("pd", 1'b0, 4'h0, 4'h9);
    expect_write("pd", 1'b1, 4'h0, 4'h9);
    start_session();
    check("restart", 32'({ifs.word_count_o, ifs.bl_address_o}), 32'd0);
    send_word(4'h6);
    expect_write("restart", 1'b0, 4'h0, 4'h6);
    expect_write("restart", 1'b1, 4'h0, 4'h6);

    // Asynchronous reset while in ACK
    @(posedge clk); #1;
    data   = 4'hC;
    strobe = 1'b1;
    wait_ack_rise("rst_ack_rise");
    expect_write("pre_rst", 1'b0, 4'h1, 4'hC);
    expect_write("pre_rst", 1'b1, 4'h1, 4'hC);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_idle("rst_async");
    prog_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_no_write", 32'(wq_s.size() + wq_w.size()), 32'd0);
    check("post_rst_idle", 32'({ifs.bl_programm_o, ifs.ack_o, ifw.bl_programm_o, ifw.ack_o}), 32'd0);
    strobe = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
